// File: rtl/regfile.sv
// RV32I integer register file: two combinational read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero, async clear on rst.
module regfile #(
  parameter int register_count = 32,
  parameter int data_length    = 32,
  localparam int AW = (register_count > 1) ? $clog2(register_count) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          r_addr_reg1,
  input  logic [AW-1:0]          r_addr_reg2,
  input  logic [AW-1:0]          w_addr_reg,
  input  logic [data_length-1:0] w_data_reg,
  input  logic                   w_ctrl_reg,
  output logic [data_length-1:0] r_data_reg1,
  output logic [data_length-1:0] r_data_reg2
);

  logic [data_length-1:0] mem [0:register_count-1];
  logic                   wr_valid;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return (32'(a) < register_count);
  endfunction

  // A write is real only when it targets a live, non-zero entry outside reset.
  assign wr_valid = !rst && w_ctrl_reg && (w_addr_reg != '0) && addr_in_range(w_addr_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < register_count; i++) mem[i] <= '0;
    end else if (wr_valid) begin
      mem[w_addr_reg] <= w_data_reg;
    end
  end

  // Bypass lets a same-cycle reader see writeback data before it commits.
  always_comb begin
    r_data_reg1 = '0;
    if (rst) r_data_reg1 = '0;
    else if (wr_valid && (r_addr_reg1 == w_addr_reg)) r_data_reg1 = w_data_reg;
    else if ((r_addr_reg1 != '0) && addr_in_range(r_addr_reg1)) r_data_reg1 = mem[r_addr_reg1];
  end

  always_comb begin
    r_data_reg2 = '0;
    if (rst) r_data_reg2 = '0;
    else if (wr_valid && (r_addr_reg2 == w_addr_reg)) r_data_reg2 = w_data_reg;
    else if ((r_addr_reg2 != '0) && addr_in_range(r_addr_reg2)) r_data_reg2 = mem[r_addr_reg2];
  end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed literal checks plus randomized traffic compared
// every cycle against an array-based model of the architectural registers.
module tb_regfile;
  logic        clk;
  logic        rst;
  logic [4:0]  r_addr_reg1, r_addr_reg2, w_addr_reg;
  logic [31:0] w_data_reg;
  logic        w_ctrl_reg;
  logic [31:0] r_data_reg1, r_data_reg2;

  int total = 0;
  int bad = 0;
  bit compare_on = 0;
  logic [31:0] model [32];

  regfile #(.register_count(32), .data_length(32)) dut (
    .clk(clk), .rst(rst),
    .r_addr_reg1(r_addr_reg1), .r_addr_reg2(r_addr_reg2),
    .w_addr_reg(w_addr_reg), .w_data_reg(w_data_reg), .w_ctrl_reg(w_ctrl_reg),
    .r_data_reg1(r_data_reg1), .r_data_reg2(r_data_reg2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Model: architectural state, cleared the instant rst rises.
  initial for (int i = 0; i < 32; i++) model[i] = 32'h0;
  always @(posedge rst) for (int i = 0; i < 32; i++) model[i] = 32'h0;
  always @(posedge clk)
    if (!rst && w_ctrl_reg && w_addr_reg != 5'd0) model[w_addr_reg] = w_data_reg;

  function automatic logic [31:0] expect_read(input logic [4:0] a);
    if (rst) return 32'h0;
    if (w_ctrl_reg && w_addr_reg != 5'd0 && a == w_addr_reg) return w_data_reg;
    if (a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      check("model_port1", r_data_reg1, expect_read(r_addr_reg1));
      check("model_port2", r_data_reg2, expect_read(r_addr_reg2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    w_ctrl_reg = c; w_addr_reg = wa; w_data_reg = wd;
    r_addr_reg1 = a1; r_addr_reg2 = a2;
  endtask

  initial begin
    logic [4:0] i5;
    rst = 1;
    drive(0, 0, 0, 5, 9);
    #2;
    check("reset_port1", r_data_reg1, 32'h0);
    check("reset_port2", r_data_reg2, 32'h0);
    step(); step();
    rst = 0;
    compare_on = 1;

    // basic write with bypass, then stored value
    drive(1, 8, 32'd3, 8, 0);
    #2;
    check("basic_bypass", r_data_reg1, 32'd3);
    check("basic_port2_zero", r_data_reg2, 32'h0);
    step();
    drive(0, 8, 32'd3, 8, 0);
    #2;
    check("basic_stored", r_data_reg1, 32'd3);
    check("basic_port2_after", r_data_reg2, 32'h0);
    step();

    // x0 is hardwired
    drive(1, 0, 32'hDEADBEEF, 0, 0);
    #2;
    check("x0_before_edge", r_data_reg1, 32'h0);
    step();
    drive(0, 0, 32'h0, 0, 0);
    #2;
    check("x0_after_edge", r_data_reg1, 32'h0);
    step();

    // write disable
    drive(0, 5, 32'h1234, 5, 0);
    step();
    #1;
    check("write_disable", r_data_reg1, 32'h0);

    // dual port and independent bypass
    drive(1, 10, 32'hAAAA_0000, 0, 0);
    step();
    drive(1, 11, 32'h5555_FFFF, 0, 0);
    step();
    drive(0, 0, 32'h0, 10, 11);
    #2;
    check("dual_port1", r_data_reg1, 32'hAAAA_0000);
    check("dual_port2", r_data_reg2, 32'h5555_FFFF);
    drive(1, 11, 32'h77, 10, 11);
    #2;
    check("bypass_port2", r_data_reg2, 32'h77);
    check("nobypass_port1", r_data_reg1, 32'hAAAA_0000);
    step();
    drive(1, 12, 32'hCAFE_F00D, 12, 12);
    #2;
    check("both_bypass_p1", r_data_reg1, 32'hCAFE_F00D);
    check("both_bypass_p2", r_data_reg2, 32'hCAFE_F00D);
    step();

    // sweep
    for (int i = 1; i < 32; i++) begin
      i5 = 5'(i);
      drive(1, i5, ~32'(i), 0, 0);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      i5 = 5'(i);
      drive(0, 0, 32'h0, i5, 5'(31 - i));
      #2;
      check("sweep_port1", r_data_reg1, (i == 0) ? 32'h0 : ~32'(i));
      check("sweep_port2", r_data_reg2, (i == 31) ? 32'h0 : ~32'(31 - i));
      step();
    end

    // reset clear mid-cycle
    for (int i = 1; i < 32; i++) begin
      i5 = 5'(i);
      drive(1, i5, 32'(i), 0, 0);
      step();
    end
    drive(1, 7, 32'd99, 7, 31);
    #1;
    check("pre_reset_bypass", r_data_reg1, 32'd99);
    check("pre_reset_stored", r_data_reg2, 32'd31);
    #1;
    rst = 1;
    #1;
    check("async_clear_p1", r_data_reg1, 32'h0);
    check("async_clear_p2", r_data_reg2, 32'h0);
    step();
    #1;
    check("write_ignored_in_rst", r_data_reg1, 32'h0);
    rst = 0;
    drive(0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      i5 = 5'(i);
      drive(0, 0, 32'h0, i5, i5);
      #2;
      check("post_reset_zero", r_data_reg1, 32'h0);
      step();
    end

    // randomized traffic, occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      if ($urandom_range(0, 7) == 0) r_addr_reg1 = w_addr_reg;
      if ($urandom_range(0, 7) == 0) r_addr_reg2 = w_addr_reg;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;
    step();
    compare_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
